ethernet_rx_framer: RTL and testbench
=====================================

// Module: ethernet_rx_framer
// PURPOSE
//  Downstream of the MII nibble receiver: takes its zero-extended nibble stream
//  (bits [3:0] valid) and turns it into framed bytes. Strips preamble/SFD, packs
//  nibbles low-first into bytes, marks start/end of frame, checks the CRC-32 FCS
//  and length, and flags errors on the last byte. No back-pressure: MII cannot stall.
// PARAMETERS
//  MIN_PRE_NIB  7     min 0x5 nibbles before SFD nibble 0xD (7 = 3.5 bytes)
//  MIN_FRAME    64    min frame bytes incl. FCS; fewer -> err_short
//  MAX_FRAME    1518  max frame bytes incl. FCS; more -> truncate, err_long
// PORTS
//  clk         in   1   rising-edge clock, same domain as nibble receiver
//  rst         in   1   asynchronous, active-low reset
//  data_in     in   8   nibble in [3:0]; [7:4] ignored
//  valid_in    in   1   nibble valid; low = inter-frame gap
//  m_data      out  8   frame byte (DA first, FCS bytes included)
//  m_valid     out  1   m_data valid, single-cycle strobe per byte
//  m_sof       out  1   first byte of frame (with m_valid)
//  m_eof       out  1   last byte of frame (with m_valid)
//  m_status    out  4   {dribble,long,short,crc} error bits; valid only with m_eof
//  m_len       out  16  frame byte count; valid only with m_eof
//  frames_ok   out  16  saturating count of clean frames
//  frames_err  out  16  saturating count of frames ending with m_status != 0
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, hold register empty, CRC = 32'hFFFFFFFF.
//  FSM (advances only on valid_in or its falling edge):
//   IDLE: valid_in & nib==5 -> PRE (pre_cnt=1); any other nibble -> DROP.
//   PRE: nib==5 -> pre_cnt++ (saturate 15); nib==D & pre_cnt>=MIN_PRE_NIB -> DATA;
//        nib==D short, or other value -> DROP; valid_in low -> IDLE, no output.
//   DATA: nibble phase toggles; phase0 latches low nibble, phase1 completes byte
//        {nib,low}, updates CRC-32 (poly 04C11DB7, reflected, per byte) and byte count.
//   DROP: ignore input until valid_in low -> IDLE; never emits output.
//  One-byte hold: completed byte goes into hold; if hold was full, previous byte
//   is emitted (m_valid=1, m_sof=1 if it is frame byte 0). Latency: byte emitted
//   the cycle after the next byte completes, or at end of frame.
//  End of frame: first cycle with valid_in=0 in DATA: if hold full, emit it with
//   m_eof=1, m_len=count, m_status set:
//    crc: CRC reg != residue 32'hC704DD7B; short: count<MIN_FRAME;
//    dribble: phase==1 (odd nibble, trailing nibble discarded); long: never here.
//   Zero completed bytes after SFD: no output, no counter change. -> IDLE.
//  Overlength: byte completes with count==MAX_FRAME: emit hold with m_eof=1,
//   m_len=MAX_FRAME, status long=1 (crc bit 0), new byte discarded -> DROP.
//  Single-byte frame: emitted with m_sof=m_eof=1.
//  m_valid/m_sof/m_eof are 1-cycle pulses; m_data/m_len/m_status hold last value.
//  Counters increment on the m_eof cycle, saturate at 16'hFFFF; reset only by rst.
//  valid_in reasserting the cycle after falling edge starts a new frame in IDLE.
//  Reset mid-frame: immediate return to reset state; partial frame not flagged.
// STRUCTURE
//  Shared package eth_pkg: CRC32_POLY, CRC32_RESIDUE, PREAMBLE_NIB=4'h5,
//   SFD_NIB=4'hD, rx_state_t enum {IDLE,PRE,DATA,DROP}, status bit indices.
//  Sub-module eth_crc32_d8: combinational next-CRC for one byte (reused by TX FCS).
//  Top holds FSM, nibble packer, hold register, length/status logic, counters.
// TESTING
//  1 15x5,D, 60 payload bytes + correct FCS, gap -> 64 m_valid, sof on byte 0,
//    eof on byte 63, m_len=64, m_status=0, frames_ok=1.
//  2 Same frame, one payload bit flipped -> eof with m_status=4'b0001, frames_err=1.
//  3 Valid 20-byte frame incl. good FCS -> m_len=20, m_status=4'b0010.
//  4 64-byte good frame + 1 extra nibble -> m_len=64, m_status=4'b1000.
//  5 1600-byte frame -> eof at byte 1518, m_status=4'b0100, no output till next
//    frame; following good 64-byte frame received clean.
//  6 Only 4x5 then D, or 5,5,A,... -> no m_valid; rst low mid-frame -> outputs 0,
//    next good frame passes with frames_ok=1.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet receive definitions: CRC-32 constants, framing nibbles, FSM states and status bit positions.
package eth_pkg;

  localparam int unsigned NIB_W     = 4;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned CRC_W     = 32;
  localparam int unsigned LEN_W     = 16;
  localparam int unsigned STATUS_W  = 4;
  localparam int unsigned PRE_CNT_W = 4;

  localparam logic [CRC_W-1:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [CRC_W-1:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [CRC_W-1:0] CRC32_RESIDUE = 32'hC704DD7B;

  localparam logic [NIB_W-1:0] PREAMBLE_NIB = 4'h5;
  localparam logic [NIB_W-1:0] SFD_NIB      = 4'hD;

  localparam int unsigned ST_CRC     = 0;
  localparam int unsigned ST_SHORT   = 1;
  localparam int unsigned ST_LONG    = 2;
  localparam int unsigned ST_DRIBBLE = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } rx_state_t;

  function automatic logic [LEN_W-1:0] sat_inc16(input logic [LEN_W-1:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational CRC-32 step for one byte, bits consumed LSB first (wire order).
// Register is kept MSB-first, so a good frame leaves the classic 0xC704DD7B residue.
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic [CRC_W-1:0]  crc_in,
  input  logic [BYTE_W-1:0] data,
  output logic [CRC_W-1:0]  crc_next_c
);

  logic [CRC_W-1:0] crc_w;

  always_comb begin
    crc_w = crc_in;
    for (int i = 0; i < 8; i++) begin
      crc_w = {crc_w[CRC_W-2:0], 1'b0} ^ ({CRC_W{crc_w[CRC_W-1] ^ data[i]}} & CRC32_POLY);
    end
    crc_next_c = crc_w;
  end

endmodule

// File: rtl/ethernet_rx_framer.sv
// MII nibble stream to framed bytes: strips preamble/SFD, packs nibbles, checks FCS
// and length, and reports per-frame status plus clean/errored frame counters.
module ethernet_rx_framer
  import eth_pkg::*;
#(
  parameter int unsigned MIN_PRE_NIB = 7,
  parameter int unsigned MIN_FRAME   = 64,
  parameter int unsigned MAX_FRAME   = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_in,
  input  logic        valid_in,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_sof,
  output logic        m_eof,
  output logic [3:0]  m_status,
  output logic [15:0] m_len,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_err
);

  rx_state_t               state_q, state_d;
  logic [PRE_CNT_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic                    phase_q, phase_d;
  logic [NIB_W-1:0]        low_q, low_d;
  logic [BYTE_W-1:0]       hold_q, hold_d;
  logic                    hold_full_q, hold_full_d;
  logic [LEN_W-1:0]        count_q, count_d;
  logic [CRC_W-1:0]        crc_q, crc_d;
  logic [BYTE_W-1:0]       m_data_q, m_data_d;
  logic                    m_valid_q, m_valid_d;
  logic                    m_sof_q, m_sof_d;
  logic                    m_eof_q, m_eof_d;
  logic [STATUS_W-1:0]     m_status_q, m_status_d;
  logic [LEN_W-1:0]        m_len_q, m_len_d;
  logic [LEN_W-1:0]        frames_ok_q, frames_ok_d;
  logic [LEN_W-1:0]        frames_err_q, frames_err_d;

  logic [NIB_W-1:0]        nib_c;
  logic [BYTE_W-1:0]       byte_c;
  logic [CRC_W-1:0]        crc_next_c;
  logic                    unused_hi_c;

  assign nib_c       = data_in[3:0];
  assign byte_c      = {nib_c, low_q};
  assign unused_hi_c = ^data_in[7:4];

  eth_crc32_d8 u_crc (
    .crc_in     (crc_q),
    .data       (byte_c),
    .crc_next_c (crc_next_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pre_cnt_q    <= '0;
      phase_q      <= 1'b0;
      low_q        <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      count_q      <= '0;
      crc_q        <= CRC32_INIT;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      m_sof_q      <= 1'b0;
      m_eof_q      <= 1'b0;
      m_status_q   <= '0;
      m_len_q      <= '0;
      frames_ok_q  <= '0;
      frames_err_q <= '0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      phase_q      <= phase_d;
      low_q        <= low_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      count_q      <= count_d;
      crc_q        <= crc_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      m_sof_q      <= m_sof_d;
      m_eof_q      <= m_eof_d;
      m_status_q   <= m_status_d;
      m_len_q      <= m_len_d;
      frames_ok_q  <= frames_ok_d;
      frames_err_q <= frames_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    phase_d      = phase_q;
    low_d        = low_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    count_d      = count_q;
    crc_d        = crc_q;
    m_data_d     = m_data_q;
    m_valid_d    = 1'b0;
    m_sof_d      = 1'b0;
    m_eof_d      = 1'b0;
    m_status_d   = m_status_q;
    m_len_d      = m_len_q;
    frames_ok_d  = frames_ok_q;
    frames_err_d = frames_err_q;

    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          if (nib_c == PREAMBLE_NIB) begin
            state_d   = PRE;
            pre_cnt_d = 4'd1;
          end else begin
            state_d = DROP;
          end
        end
      end

      PRE: begin
        if (!valid_in) begin
          state_d = IDLE;
        end else if (nib_c == PREAMBLE_NIB) begin
          if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
        end else if (nib_c == SFD_NIB && pre_cnt_q >= 4'(MIN_PRE_NIB)) begin
          state_d     = DATA;
          phase_d     = 1'b0;
          count_d     = '0;
          crc_d       = CRC32_INIT;
          hold_full_d = 1'b0;
        end else begin
          state_d = DROP;
        end
      end

      DATA: begin
        if (valid_in) begin
          if (!phase_q) begin
            low_d   = nib_c;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            // Overlength: close the frame on the held byte, discard the new one
            if (count_q == 16'(MAX_FRAME)) begin
              m_valid_d              = 1'b1;
              m_eof_d                = 1'b1;
              m_sof_d                = (count_q == 16'd1);
              m_data_d               = hold_q;
              m_len_d                = count_q;
              m_status_d             = '0;
              m_status_d[ST_LONG]    = 1'b1;
              hold_full_d            = 1'b0;
              state_d                = DROP;
            end else begin
              count_d     = count_q + 16'd1;
              crc_d       = crc_next_c;
              hold_d      = byte_c;
              hold_full_d = 1'b1;
              if (hold_full_q) begin
                m_valid_d = 1'b1;
                m_sof_d   = (count_q == 16'd1);
                m_data_d  = hold_q;
              end
            end
          end
        end else begin
          state_d     = IDLE;
          hold_full_d = 1'b0;
          if (hold_full_q) begin
            m_valid_d              = 1'b1;
            m_eof_d                = 1'b1;
            m_sof_d                = (count_q == 16'd1);
            m_data_d               = hold_q;
            m_len_d                = count_q;
            m_status_d             = '0;
            m_status_d[ST_CRC]     = (crc_q != CRC32_RESIDUE);
            m_status_d[ST_SHORT]   = (count_q < 16'(MIN_FRAME));
            m_status_d[ST_DRIBBLE] = phase_q;
          end
        end
      end

      DROP: begin
        if (!valid_in) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (m_eof_d) begin
      if (m_status_d == '0) frames_ok_d  = sat_inc16(frames_ok_q);
      else                  frames_err_d = sat_inc16(frames_err_q);
    end
  end

  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign m_sof      = m_sof_q;
  assign m_eof      = m_eof_q;
  assign m_status   = m_status_q;
  assign m_len      = m_len_q;
  assign frames_ok  = frames_ok_q;
  assign frames_err = frames_err_q;

endmodule

// File: tb/tb_ethernet_rx_framer.sv
// Directed bench for ethernet_rx_framer: nibble-level frames with bench-computed FCS,
// received bytes captured by a monitor and checked per frame.
module tb_ethernet_rx_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        valid_in = 1'b0;
  logic [7:0]  m_data;
  logic        m_valid, m_sof, m_eof;
  logic [3:0]  m_status;
  logic [15:0] m_len, frames_ok, frames_err;

  int tests = 0;
  int failed = 0;

  logic [7:0] fr   [0:1599];
  logic [7:0] rx_b [0:8191];
  int rx_n = 0, sof_cnt = 0, sof_at = 0, eof_cnt = 0, eof_at = 0;
  int b_rx, b_sof, b_eof;

  always #5 clk = ~clk;

  ethernet_rx_framer dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_sof      (m_sof),
    .m_eof      (m_eof),
    .m_status   (m_status),
    .m_len      (m_len),
    .frames_ok  (frames_ok),
    .frames_err (frames_err)
  );

  // Capture every emitted byte and where the frame markers landed
  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      rx_b[rx_n & 8191] = m_data;
      if (m_sof) begin sof_cnt++; sof_at = rx_n; end
      if (m_eof) begin eof_cnt++; eof_at = rx_n; end
      rx_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Payload pattern plus standard Ethernet FCS (reflected CRC-32, complemented, LSB byte first)
  function automatic void build(input int n, input int seed, input bit fcs);
    logic [31:0] c;
    int pl;
    pl = fcs ? n - 4 : n;
    for (int i = 0; i < pl; i++) fr[i] = 8'(i * 37 + seed);
    if (fcs) begin
      c = 32'hFFFFFFFF;
      for (int i = 0; i < pl; i++) begin
        c = c ^ {24'h0, fr[i]};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      c = ~c;
      fr[pl]     = c[7:0];
      fr[pl + 1] = c[15:8];
      fr[pl + 2] = c[23:16];
      fr[pl + 3] = c[31:24];
    end
  endfunction

  task automatic send_nib(input logic [3:0] n);
    @(negedge clk);
    data_in  = {4'hA, n};
    valid_in = 1'b1;
  endtask

  task automatic gap(input int k);
    repeat (k) begin
      @(negedge clk);
      valid_in = 1'b0;
      data_in  = 8'h00;
    end
  endtask

  task automatic send_frame(input int n, input int pre, input bit odd, input int gp);
    repeat (pre) send_nib(4'h5);
    send_nib(4'hD);
    for (int i = 0; i < n; i++) begin
      send_nib(fr[i][3:0]);
      send_nib(fr[i][7:4]);
    end
    if (odd) send_nib(4'h3);
    gap(gp);
  endtask

  task automatic mark();
    b_rx  = rx_n;
    b_sof = sof_cnt;
    b_eof = eof_cnt;
  endtask

  task automatic check_frame(input string tag, input int exp_n, input int exp_len,
                             input logic [3:0] exp_st, input logic [3:0] st_mask,
                             input int exp_ok, input int exp_err);
    int mism;
    chk({tag, ".bytes"}, rx_n - b_rx, exp_n);
    chk({tag, ".eofs"}, eof_cnt - b_eof, (exp_n > 0) ? 1 : 0);
    if (exp_n > 0) begin
      chk({tag, ".sofs"}, sof_cnt - b_sof, 1);
      chk({tag, ".sof_pos"}, sof_at - b_rx, 0);
      chk({tag, ".eof_pos"}, eof_at - b_rx, exp_n - 1);
      chk({tag, ".len"}, m_len, exp_len);
      chk({tag, ".status"}, m_status & st_mask, exp_st);
      mism = 0;
      for (int i = 0; i < exp_n; i++) if (rx_b[(b_rx + i) & 8191] !== fr[i]) mism++;
      chk({tag, ".data"}, mism, 0);
    end
    chk({tag, ".frames_ok"}, frames_ok, exp_ok);
    chk({tag, ".frames_err"}, frames_err, exp_err);
  endtask

  initial begin
    #12;
    chk("rst.m_valid", m_valid, 0);
    chk("rst.m_len", m_len, 0);
    chk("rst.m_status", m_status, 0);
    chk("rst.frames_ok", frames_ok, 0);
    chk("rst.frames_err", frames_err, 0);
    @(negedge clk);
    rst = 1'b1;
    gap(2);

    // Clean minimum-size frame behind a long preamble
    build(64, 1, 1'b1);
    mark(); send_frame(64, 15, 1'b0, 4);
    check_frame("good64", 64, 64, 4'b0000, 4'hF, 1, 0);

    // Same frame with one payload bit flipped
    build(64, 1, 1'b1);
    fr[10] = fr[10] ^ 8'h08;
    mark(); send_frame(64, 15, 1'b0, 4);
    check_frame("crcerr", 64, 64, 4'b0001, 4'hF, 1, 1);

    // Runt with good FCS, minimum legal preamble
    build(20, 3, 1'b1);
    mark(); send_frame(20, 7, 1'b0, 4);
    check_frame("short20", 20, 20, 4'b0010, 4'hF, 1, 2);

    // Trailing odd nibble
    build(64, 5, 1'b1);
    mark(); send_frame(64, 15, 1'b1, 4);
    check_frame("dribble", 64, 64, 4'b1000, 4'hF, 1, 3);

    // Oversize frame, then the next frame starts right after a one-cycle gap
    build(1600, 7, 1'b1);
    mark(); send_frame(1600, 15, 1'b0, 1);
    send_nib(4'h5);
    check_frame("long", 1518, 1518, 4'b0100, 4'hF, 1, 4);
    build(64, 9, 1'b1);
    mark(); send_frame(64, 14, 1'b0, 4);
    check_frame("after_long", 64, 64, 4'b0000, 4'hF, 2, 4);

    // Single-byte frame: markers coincide, always short
    build(1, 11, 1'b0);
    mark(); send_frame(1, 15, 1'b0, 4);
    check_frame("single", 1, 1, 4'b0010, 4'b1110, 2, 5);

    // SFD immediately followed by the gap
    mark(); send_frame(0, 15, 1'b0, 4);
    check_frame("empty", 0, 0, 4'b0000, 4'hF, 2, 5);

    // Preamble one nibble too short
    build(64, 13, 1'b1);
    mark(); send_frame(10, 6, 1'b0, 4);
    check_frame("shortpre", 0, 0, 4'b0000, 4'hF, 2, 5);

    // Bad nibble inside the preamble
    mark();
    send_nib(4'h5); send_nib(4'h5); send_nib(4'hA);
    send_frame(10, 8, 1'b0, 4);
    check_frame("badpre", 0, 0, 4'b0000, 4'hF, 2, 5);

    // Reset in the middle of a frame
    build(64, 15, 1'b1);
    send_frame(30, 15, 1'b0, 0);
    @(negedge clk);
    rst      = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    #1;
    chk("midrst.m_valid", m_valid, 0);
    chk("midrst.m_data", m_data, 0);
    chk("midrst.m_len", m_len, 0);
    chk("midrst.frames_ok", frames_ok, 0);
    chk("midrst.frames_err", frames_err, 0);
    @(negedge clk);
    rst = 1'b1;
    gap(2);
    build(64, 17, 1'b1);
    mark(); send_frame(64, 15, 1'b0, 4);
    check_frame("post_rst", 64, 64, 4'b0000, 4'hF, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
